// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// one-entry skid buffer and IF/ID pipeline register with stall/flush.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | request outstanding at PC; word loads IF/ID when accepted
// S_HOLD  | word returned while ID stalled; parked in skid, no request
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] NPC_out,
  input  logic        stall,
  input  logic        flush,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] NPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        fetch_busy,
  output logic        ID_valid,
  output logic [31:0] ID_instr,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_NPC
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] skid_instr, skid_pc;
  logic        capture, load_fetch, load_skid, bubble;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (imem_ready && stall) state_nxt = S_HOLD;
      S_HOLD:  if (!stall)              state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  // imem_ready is only meaningful while a request is actually driven
  always_comb begin
    imem_req   = rst_n && (state == S_FETCH);
    fetch_busy = imem_req && !imem_ready;
    capture    = imem_req && imem_ready && stall;
    load_fetch = imem_req && imem_ready && !stall && !flush;
    load_skid  = (state == S_HOLD) && !stall && !flush;
    bubble     = !stall && !load_fetch && !load_skid;
  end

  assign NPC       = PC + 32'd4;
  assign imem_addr = {PC[31:2], 2'b00};

  // Hold behaviour comes from the selector returning PC on NPC_out.
  always_ff @(posedge clk) begin
    if (!rst_n) PC <= RESET_PC;
    else        PC <= NPC_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (capture) begin
      skid_instr <= imem_rdata;
      skid_pc    <= PC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ID_valid <= 1'b0;
      ID_instr <= '0;
      ID_PC    <= '0;
      ID_NPC   <= '0;
    end else if (load_fetch) begin
      ID_valid <= 1'b1;
      ID_instr <= imem_rdata;
      ID_PC    <= PC;
      ID_NPC   <= PC + 32'd4;
    end else if (load_skid) begin
      ID_valid <= 1'b1;
      ID_instr <= skid_instr;
      ID_PC    <= skid_pc;
      ID_NPC   <= skid_pc + 32'd4;
    end else if (bubble) begin
      ID_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: bench-side selector and memory
// models, scoreboard of expected IF/ID contents.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk, rst_n, stall, flush, imem_ready;
  logic [31:0] NPC_out, imem_rdata, target;
  logic [31:0] PC, NPC, imem_addr, ID_instr, ID_PC, ID_NPC;
  logic        imem_req, fetch_busy, ID_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .NPC_out(NPC_out), .stall(stall), .flush(flush),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC(PC), .NPC(NPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .fetch_busy(fetch_busy),
    .ID_valid(ID_valid), .ID_instr(ID_instr), .ID_PC(ID_PC), .ID_NPC(ID_NPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  // Selector model: hold on bubble/conflict, then redirect, then sequential.
  always_comb begin
    NPC_out = NPC;
    if (fetch_busy || stall) NPC_out = PC;
    else if (flush)          NPC_out = target;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0; stall = 0; flush = 0; imem_ready = 0; target = 0;
    tick; tick;
    n_tests++; if (PC !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", PC, RST_PC); end
    n_tests++; if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ID_valid); end
    n_tests++; if ({ID_instr, ID_PC, ID_NPC} !== 96'd0) begin n_fail++; $display("FAIL reset_ifid: got %h %h %h expected zeros", ID_instr, ID_PC, ID_NPC); end
    n_tests++; if ({imem_req, fetch_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_req: got %b%b expected 00", imem_req, fetch_busy); end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    rst_n = 1; imem_ready = 1; #1;
    for (int i = 0; i < 4; i++) begin
      a = RST_PC + 32'(4 * i);
      n_tests++; if (imem_addr !== a) begin n_fail++; $display("FAIL seq_addr: got %h expected %h", imem_addr, a); end
      n_tests++; if (NPC !== a + 4) begin n_fail++; $display("FAIL seq_npc: got %h expected %h", NPC, a + 4); end
      sb.push_back('{pc: a, instr: mem_word(a)});
      tick;
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL seq_sb: got empty expected entry"); end
      else begin
        e = sb.pop_front();
        if (ID_valid !== 1'b1 || ID_PC !== e.pc || ID_instr !== e.instr || ID_NPC !== e.pc + 4) begin
          n_fail++;
          $display("FAIL seq_ifid: got v=%b pc=%h i=%h npc=%h expected v=1 pc=%h i=%h npc=%h",
                   ID_valid, ID_PC, ID_instr, ID_NPC, e.pc, e.instr, e.pc + 4);
        end
      end
    end
  endtask

  task automatic test_wait;
    imem_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (fetch_busy !== 1'b1 || imem_addr !== 32'h0040_0010) begin n_fail++; $display("FAIL wait_busy: got busy=%b addr=%h expected busy=1 addr=00400010", fetch_busy, imem_addr); end
      tick;
      n_tests++; if (ID_valid !== 1'b0 || PC !== 32'h0040_0010) begin n_fail++; $display("FAIL wait_hold: got v=%b pc=%h expected v=0 pc=00400010", ID_valid, PC); end
    end
    imem_ready = 1; #1;
    n_tests++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL wait_ready_busy: got %b expected 0", fetch_busy); end
    sb.push_back('{pc: 32'h0040_0010, instr: mem_word(32'h0040_0010)});
    tick;
    n_tests++;
    e = sb.pop_front();
    if (ID_valid !== 1'b1 || ID_PC !== e.pc || ID_instr !== e.instr) begin
      n_fail++; $display("FAIL wait_load: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", ID_valid, ID_PC, ID_instr, e.pc, e.instr);
    end
  endtask

  task automatic test_stall;
    repeat (3) tick;
    stall = 1; #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0020) begin n_fail++; $display("FAIL stall_req: got req=%b addr=%h expected req=1 addr=00400020", imem_req, imem_addr); end
    tick;
    n_tests++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin n_fail++; $display("FAIL stall_hold_req: got req=%b busy=%b expected 0 0", imem_req, fetch_busy); end
    n_tests++; if (ID_valid !== 1'b1 || ID_PC !== 32'h0040_001C || PC !== 32'h0040_0020) begin n_fail++; $display("FAIL stall_hold_ifid: got v=%b idpc=%h pc=%h expected v=1 idpc=0040001c pc=00400020", ID_valid, ID_PC, PC); end
    imem_ready = 0; #1;
    tick;
    n_tests++; if (ID_valid !== 1'b1 || ID_PC !== 32'h0040_001C || imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold2: got v=%b idpc=%h req=%b expected v=1 idpc=0040001c req=0", ID_valid, ID_PC, imem_req); end
    stall = 0; #1;
    sb.push_back('{pc: 32'h0040_0020, instr: mem_word(32'h0040_0020)});
    tick;
    n_tests++;
    e = sb.pop_front();
    if (ID_valid !== 1'b1 || ID_PC !== e.pc || ID_instr !== e.instr) begin
      n_fail++; $display("FAIL stall_release: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", ID_valid, ID_PC, ID_instr, e.pc, e.instr);
    end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0024) begin n_fail++; $display("FAIL stall_next_req: got req=%b addr=%h expected req=1 addr=00400024", imem_req, imem_addr); end
  endtask

  task automatic test_flush;
    imem_ready = 1; flush = 1; target = 32'h0040_0100; #1;
    tick;
    n_tests++; if (ID_valid !== 1'b0 || imem_addr !== 32'h0040_0100) begin n_fail++; $display("FAIL flush_squash: got v=%b addr=%h expected v=0 addr=00400100", ID_valid, imem_addr); end
    flush = 0; #1;
    sb.push_back('{pc: 32'h0040_0100, instr: mem_word(32'h0040_0100)});
    tick;
    n_tests++;
    e = sb.pop_front();
    if (ID_valid !== 1'b1 || ID_PC !== e.pc || ID_instr !== e.instr) begin
      n_fail++; $display("FAIL flush_target: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", ID_valid, ID_PC, ID_instr, e.pc, e.instr);
    end
  endtask

  task automatic test_flush_stall_hold;
    stall = 1; #1;
    tick;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fsh_enter: got req=%b expected 0", imem_req); end
    flush = 1; target = 32'h0040_0200; #1;
    tick;
    n_tests++; if (ID_valid !== 1'b1 || ID_PC !== 32'h0040_0100 || PC !== 32'h0040_0104 || imem_req !== 1'b0) begin n_fail++; $display("FAIL fsh_held: got v=%b idpc=%h pc=%h req=%b expected v=1 idpc=00400100 pc=00400104 req=0", ID_valid, ID_PC, PC, imem_req); end
    stall = 0; #1;
    tick;
    n_tests++; if (ID_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin n_fail++; $display("FAIL fsh_flush: got v=%b req=%b addr=%h expected v=0 req=1 addr=00400200", ID_valid, imem_req, imem_addr); end
    flush = 0;
  endtask

  task automatic test_wrap;
    imem_ready = 1; flush = 1; target = 32'hFFFF_FFFC; #1;
    tick;
    flush = 0; #1;
    n_tests++; if (PC !== 32'hFFFF_FFFC || NPC !== 32'h0) begin n_fail++; $display("FAIL wrap_npc: got pc=%h npc=%h expected pc=fffffffc npc=00000000", PC, NPC); end
    sb.push_back('{pc: 32'hFFFF_FFFC, instr: mem_word(32'hFFFF_FFFC)});
    tick;
    n_tests++;
    e = sb.pop_front();
    if (ID_PC !== e.pc || ID_instr !== e.instr || ID_NPC !== 32'h0) begin
      n_fail++; $display("FAIL wrap_ifid: got pc=%h i=%h npc=%h expected pc=%h i=%h npc=00000000", ID_PC, ID_instr, ID_NPC, e.pc, e.instr);
    end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); end
  endtask

  task automatic test_reset_mid_fetch;
    imem_ready = 0; #1;
    n_tests++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rmf_busy: got %b expected 1", fetch_busy); end
    tick;
    rst_n = 0; #1;
    n_tests++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rmf_forced: got req=%b busy=%b expected 0 0", imem_req, fetch_busy); end
    tick;
    imem_ready = 1; #1;
    tick;
    n_tests++; if (PC !== RST_PC || ID_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_state: got pc=%h v=%b expected pc=%h v=0", PC, ID_valid, RST_PC); end
    rst_n = 1; #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL rmf_first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RST_PC); end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_wait;
    test_stall;
    test_flush;
    test_flush_stall_hold;
    test_wrap;
    test_reset_mid_fetch;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
